// File: rtl/chan_serializer.sv
// Frame-to-sample serializer: buffers one parallel frame and emits its channels
// one per enabled cycle, back-to-back across frames when the next one is waiting.
module chan_serializer #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  localparam int COUNT_WIDTH = $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0]              dout,
  output logic                               dout_valid,
  output logic [COUNT_WIDTH-1:0]             dout_chan,
  output logic                               dout_first,
  output logic                               dout_last,
  output logic                               underrun
);

  localparam int FRAME_WIDTH = NUM_CHANNELS * DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_CHAN = COUNT_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [FRAME_WIDTH-1:0]   hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
  logic [FRAME_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic                     first_q, first_d;
  logic                     last_q, last_d;
  logic                     underrun_q, underrun_d;
  logic                     capture;
  logic                     load;
  logic [COUNT_WIDTH-1:0]   cnt_inc;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    first_d      = first_q;
    last_d       = last_q;
    dout_valid_d = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;
    cnt_inc      = cnt_q + 1'b1;
    capture      = in_valid & ~hold_full_q;

    if (ena) begin
      case (state_q)
        IDLE: begin
          load = hold_full_q;
        end
        SHIFT: begin
          if (cnt_q != LAST_CHAN) begin
            cnt_d        = cnt_inc;
            dout_d       = shift_q[DATA_WIDTH-1:0];
            shift_d      = shift_q >> DATA_WIDTH;
            dout_valid_d = 1'b1;
            first_d      = 1'b0;
            last_d       = (cnt_inc == LAST_CHAN);
          end else if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Loading consumes the buffer; channel 0 leaves immediately, the rest wait in the shifter.
    if (load) begin
      state_d      = SHIFT;
      cnt_d        = '0;
      dout_d       = hold_q[DATA_WIDTH-1:0];
      shift_d      = hold_q >> DATA_WIDTH;
      dout_valid_d = 1'b1;
      first_d      = 1'b1;
      last_d       = 1'b0;
    end

    hold_d      = capture ? din : hold_q;
    hold_full_d = capture ? 1'b1 : (load ? 1'b0 : hold_full_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
      underrun_q   <= underrun_d;
    end
  end

  assign in_ready   = ~hold_full_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_chan  = cnt_q;
  assign dout_first = first_q;
  assign dout_last  = last_q;
  assign underrun   = underrun_q;

endmodule
